// File: rtl/muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// muldiv_unit_if
//   Request/result bundle between the execute stage and the multiply/divide
//   unit.
//   master (execute stage): drives start, op, a, b, cancel; observes busy,
//                           done, hi, lo.
//   slave  (muldiv_unit)  : the mirror image.
//   Signals:
//     start  - request, honoured only while busy is low
//     op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//     a, b   - rs / rt operands
//     cancel - pipeline flush; aborts an in-flight operation
//     busy   - iterative operation in flight (pipeline stall)
//     done   - one-cycle pulse after HI/LO take an iterative result
//     hi, lo - architectural HI/LO registers
// ----------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit owning the HI/LO registers. Signed and
//   unsigned multiply (shift-add) and divide (restoring) run on operand
//   magnitudes for WIDTH cycles, then a single FIX cycle applies the result
//   signs and writes HI/LO. MTHI/MTLO write HI/LO directly while idle.
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous, active-low reset
//     bus - muldiv_unit_if slave modport (see interface header)
// ----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [2:0]      OP_MTHI = 3'd4;
  localparam logic [2:0]      OP_MTLO = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   operand_q;   // multiplicand or divisor magnitude
  logic               div_q;
  logic               res_neg_q;   // negate product / quotient
  logic               rem_neg_q;   // negate remainder
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  // Request decode on the live inputs.
  logic             op_signed, op_div, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    op_signed = ~bus.op[0];
    op_div    = bus.op[1];
    a_neg     = op_signed & bus.a[WIDTH-1];
    b_neg     = op_signed & bus.b[WIDTH-1];
    mag_a     = a_neg ? (~bus.a + 1'b1) : bus.a;
    mag_b     = b_neg ? (~bus.b + 1'b1) : bus.b;
  end

  // FSM next-state and control strobes.
  logic accept, mt_hi_we, mt_lo_we, commit;

  // NOTE: every always_comb output gets a default first so no path through
  // the case/if tree leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    mt_hi_we = 1'b0;
    mt_lo_we = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        // A cancel in IDLE swallows a same-cycle start.
        if (bus.start && !bus.cancel) begin
          if (!bus.op[2]) begin
            accept  = 1'b1;
            state_d = CALC;
          end else if (bus.op == OP_MTHI) begin
            mt_hi_we = 1'b1;
          end else if (bus.op == OP_MTLO) begin
            mt_lo_we = 1'b1;
          end
        end
      end
      CALC: begin
        if (bus.cancel)            state_d = IDLE;
        else if (count_q == LAST)  state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        commit  = ~bus.cancel;
      end
      default: state_d = IDLE;
    endcase
  end

  // One iteration of the datapath.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, operand_q};
    // Partial remainder shifted left with the next dividend bit brought in.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, operand_q};
    acc_step = acc_q;
    if (div_q) begin
      // rem_sh < 2*divisor, so the MSB of the difference is a clean borrow.
      if (!rem_diff[WIDTH]) acc_step = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_step = {rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};
    end else begin
      if (acc_q[0]) acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      else          acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  // Sign fix-up applied in the FIX cycle.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

  always_comb begin
    prod_fix = res_neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = res_neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    fix_hi   = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = div_q ? quo_fix : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the working registers (acc_q, operand_q, flags) are reset along
  // with HI/LO; they are few and a known start keeps X out of simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      div_q     <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= commit;
      if (accept) begin
        count_q   <= '0;
        div_q     <= op_div;
        operand_q <= op_div ? mag_b : mag_a;
        acc_q     <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
        // A zero divisor keeps the quotient at all-ones; the remainder path
        // then reproduces the original dividend on its own.
        res_neg_q <= (a_neg ^ b_neg) & ~(op_div & (bus.b == '0));
        rem_neg_q <= a_neg;
      end
      if (mt_hi_we) hi_q <= bus.a;
      if (mt_lo_we) lo_q <= bus.a;
      if (state_q == CALC && !bus.cancel) begin
        acc_q   <= acc_step;
        count_q <= count_q + 1'b1;
      end
      if (commit) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed and randomized checks of muldiv_unit against an arithmetic
//   reference model (64-bit products, native division with truncation).
//   Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Architectural HI/LO as the bench expects them.
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: what HI/LO must hold after op completes.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    h = exp_hi;
    l = exp_lo;
    case (op)
      3'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = ua * ub;      h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin h = a; l = '1; end
        else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      end
      3'd3: begin
        if (b == 32'd0) begin h = a; l = '1; end
        else begin p = ua % ub; h = p[31:0]; p = ua / ub; l = p[31:0]; end
      end
      default: ;
    endcase
  endfunction

  // Issue an iterative op and follow it to its done pulse. With b2b set the
  // start is driven in the current (done) cycle. poke >= 0 issues an MTLO
  // request that many falling edges into the busy window.
  task automatic run_iter(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit b2b, input int poke);
    logic [31:0] nh, nl;
    int n;
    bit stray, held;
    if (!b2b) begin
      @(negedge clk);
      check({tag, " done idle"}, 64'(bus.done), 64'd0);
    end
    model(op, a, b, nh, nl);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    n = 0; stray = 1'b0; held = 1'b1;
    while (bus.busy && n < 100) begin
      if (bus.done) stray = 1'b1;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) held = 1'b0;
      if (n == poke) begin
        bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h1234;
      end else begin
        bus.start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    exp_hi = nh;
    exp_lo = nl;
    check({tag, " busy cycles"}, 64'(n), 64'd33);
    check({tag, " done during busy"}, 64'(stray), 64'd0);
    check({tag, " hi/lo held"}, 64'(held), 64'd1);
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    bit          stray;

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    rst = 1'b1;

    run_iter("mult -3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, -1);
    check("mult -3x7 hi const", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult -3x7 lo const", 64'(bus.lo), 64'hFFFF_FFEB);

    // Unsigned
    run_iter("multu max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    run_iter("divu 100/7", 3'd3, 32'd100, 32'd7, 1'b0, -1);

    // Signed divides
    run_iter("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    run_iter("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    check("div ovf lo const", 64'(bus.lo), 64'h8000_0000);
    run_iter("div 5/0", 3'd2, 32'd5, 32'd0, 1'b0, -1);
    run_iter("div -5/0", 3'd2, 32'hFFFF_FFFB, 32'd0, 1'b0, -1);
    run_iter("divu big/0", 3'd3, 32'hDEAD_BEEF, 32'd0, 1'b0, -1);

    // MTLO while busy is ignored (issued at E10)
    run_iter("divu poke", 3'd3, 32'd100, 32'd7, 1'b0, 9);
    check("poke lo const", 64'(bus.lo), 64'd14);

    // Cancel at E20 of a MULT
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel busy", 64'(bus.busy), 64'd0);
    check("cancel done", 64'(bus.done), 64'd0);
    stray = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) stray = 1'b1;
    end
    check("cancel quiet", 64'(stray), 64'd0);
    check("cancel hi", 64'(bus.hi), 64'(exp_hi));
    check("cancel lo", 64'(bus.lo), 64'(exp_lo));

    // Cancel in IDLE blocks a same-cycle start
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h5A5A_5A5A; bus.cancel = 1'b1;
    @(negedge clk);
    bus.op = 3'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("idle cancel hi", 64'(bus.hi), 64'(exp_hi));
    check("idle cancel busy", 64'(bus.busy), 64'd0);

    // Op 7 is a no-op
    bus.start = 1'b1; bus.op = 3'd7; bus.a = 32'h0F0F_0F0F;
    @(negedge clk);
    bus.start = 1'b0;
    check("nop busy", 64'(bus.busy), 64'd0);
    check("nop hi", 64'(bus.hi), 64'(exp_hi));
    check("nop lo", 64'(bus.lo), 64'(exp_lo));

    // Reset at E15
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd11; bus.b = 32'd13;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst hi", 64'(bus.hi), 64'd0);
    check("midrst lo", 64'(bus.lo), 64'd0);
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst done", 64'(bus.done), 64'd0);
    rst = 1'b1;
    exp_hi = '0;
    exp_lo = '0;

    // MTHI / MTLO
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hAAAA_5555;
    @(negedge clk);
    bus.start = 1'b0;
    exp_hi = 32'hAAAA_5555;
    check("mthi hi", 64'(bus.hi), 64'(exp_hi));
    check("mthi busy", 64'(bus.busy), 64'd0);
    check("mthi done", 64'(bus.done), 64'd0);
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h0BAD_F00D;
    @(negedge clk);
    bus.start = 1'b0;
    exp_lo = 32'h0BAD_F00D;
    check("mtlo lo", 64'(bus.lo), 64'(exp_lo));
    check("mtlo hi", 64'(bus.hi), 64'(exp_hi));

    // Back-to-back
    run_iter("b2b multu", 3'd1, 32'd3, 32'd4, 1'b0, -1);
    run_iter("b2b divu", 3'd3, 32'd9, 32'd2, 1'b1, -1);
    check("b2b lo const", 64'(bus.lo), 64'd4);
    check("b2b hi const", 64'(bus.hi), 64'd1);

    // Randomized operations
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(0, 3));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_iter("random", rop, ra, rb, bit'($urandom_range(0, 1)), -1);
    end

    @(negedge clk);
    check("final done", 64'(bus.done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
